rat_path_player: RTL and testbench

- Downstream consumer of the maze solver's path queue.
- Once the solver has found a route, this block rewinds the queue, reads the 2-bit direction stream one entry per step, and rebuilds the rat's coordinates from the start cell.
- Each step is presented to the display/trace logic on a valid/ready handshake.
- Step count, goal-reached and path-error status are reported when the queue is exhausted or a move leaves the maze.

---
 rtl/rat_pkg.sv | 21 ++
 rtl/rat_coord_step.sv | 43 ++++
 rtl/rat_path_player.sv | 151 +++++++++++++++
 tb/tb_rat_path_player.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rat_pkg.sv
// Shared definitions for the maze path replay logic: direction codes, player states and the
// goal corner.
package rat_pkg;

  localparam logic [1:0] DIR_YINC = 2'b00;
  localparam logic [1:0] DIR_XINC = 2'b01;
  localparam logic [1:0] DIR_XDEC = 2'b10;
  localparam logic [1:0] DIR_YDEC = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    MOVE  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } player_state_e;

  // The goal is the all-ones corner; users slice this to their coordinate width.
  localparam logic [31:0] GOAL_ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/rat_coord_step.sv
// Combinational single-step move: applies a direction code to (x, y) and flags moves that
// would leave the square maze.
module rat_coord_step
  import rat_pkg::*;
#(
  parameter int unsigned COORD_W = 4
) (
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic [1:0]         i_dir,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_out_of_range
);

  localparam logic [COORD_W-1:0] MAX_COORD = '1;
  localparam logic [COORD_W-1:0] ONE       = COORD_W'(1);

  always_comb begin
    o_x            = i_x;
    o_y            = i_y;
    o_out_of_range = 1'b0;
    unique case (i_dir)
      DIR_YINC: begin
        o_y            = i_y + ONE;
        o_out_of_range = (i_y == MAX_COORD);
      end
      DIR_XINC: begin
        o_x            = i_x + ONE;
        o_out_of_range = (i_x == MAX_COORD);
      end
      DIR_XDEC: begin
        o_x            = i_x - ONE;
        o_out_of_range = (i_x == '0);
      end
      DIR_YDEC: begin
        o_y            = i_y - ONE;
        o_out_of_range = (i_y == '0);
      end
    endcase
  end

endmodule

// File: rtl/rat_path_player.sv
// Replays the solver's direction queue from the start cell, presenting each step on a
// valid/ready handshake and reporting step count, goal and error status at the end.
module rat_path_player
  import rat_pkg::*;
#(
  parameter int unsigned COORD_W = 4,
  parameter int unsigned STEP_W  = 9,
  parameter int unsigned START_X = 0,
  parameter int unsigned START_Y = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         q_out,
  input  logic               finishq,
  output logic               rst_frontq,
  output logic               dequeue,
  output logic               move_valid,
  input  logic               move_ready,
  output logic [1:0]         move_dir,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic [STEP_W-1:0]  step_count,
  output logic               busy,
  output logic               done,
  output logic               at_goal,
  output logic               err
);

  localparam logic [COORD_W-1:0] START_XC = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] START_YC = COORD_W'(START_Y);
  localparam logic [COORD_W-1:0] GOAL     = GOAL_ALL_ONES[COORD_W-1:0];
  localparam logic [STEP_W-1:0]  STEP_MAX = '1;
  localparam logic [STEP_W-1:0]  STEP_ONE = STEP_W'(1);

  player_state_e       r_state;
  player_state_e       w_state_nxt;
  logic                r_start_q;
  logic [COORD_W-1:0]  r_x;
  logic [COORD_W-1:0]  r_y;
  logic [COORD_W-1:0]  r_px;
  logic [COORD_W-1:0]  r_py;
  logic [1:0]          r_dir;
  logic [STEP_W-1:0]   r_step;

  logic                w_start_edge;
  logic                w_load_start;
  logic                w_latch;
  logic                w_accept;
  logic [COORD_W-1:0]  w_nx;
  logic [COORD_W-1:0]  w_ny;
  logic                w_oor;

  rat_coord_step #(
    .COORD_W (COORD_W)
  ) u_coord_step (
    .i_x            (r_x),
    .i_y            (r_y),
    .i_dir          (q_out),
    .o_x            (w_nx),
    .o_y            (w_ny),
    .o_out_of_range (w_oor)
  );

  assign w_start_edge = start & ~r_start_q;

  always_comb begin
    w_state_nxt  = r_state;
    rst_frontq   = 1'b0;
    dequeue      = 1'b0;
    move_valid   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    w_load_start = 1'b0;
    w_latch      = 1'b0;
    w_accept     = 1'b0;
    unique case (r_state)
      IDLE, DONE, ERR: begin
        done = (r_state == DONE);
        err  = (r_state == ERR);
        if (w_start_edge) begin
          rst_frontq   = 1'b1;
          w_load_start = 1'b1;
          w_state_nxt  = CHECK;
        end
      end
      CHECK: begin
        busy = 1'b1;
        if (finishq) begin
          w_state_nxt = DONE;
        end else if (w_oor) begin
          w_state_nxt = ERR;
        end else begin
          w_latch     = 1'b1;
          w_state_nxt = MOVE;
        end
      end
      MOVE: begin
        busy       = 1'b1;
        move_valid = 1'b1;
        if (move_ready) begin
          dequeue     = 1'b1;
          w_accept    = 1'b1;
          w_state_nxt = CHECK;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_start_q resets high so a start level held through reset is not taken as a new edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_start_q <= 1'b1;
      r_x       <= START_XC;
      r_y       <= START_YC;
      r_px      <= START_XC;
      r_py      <= START_YC;
      r_dir     <= DIR_YINC;
      r_step    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_start_q <= start;
      if (w_load_start) begin
        r_x    <= START_XC;
        r_y    <= START_YC;
        r_step <= '0;
      end else if (w_accept) begin
        r_x <= r_px;
        r_y <= r_py;
        if (r_step != STEP_MAX) begin
          r_step <= r_step + STEP_ONE;
        end
      end
      if (w_latch) begin
        r_px  <= w_nx;
        r_py  <= w_ny;
        r_dir <= q_out;
      end
    end
  end

  assign move_dir   = r_dir;
  assign x_o        = move_valid ? r_px : r_x;
  assign y_o        = move_valid ? r_py : r_y;
  assign step_count = r_step;
  assign at_goal    = done && (r_x == GOAL) && (r_y == GOAL);

endmodule

// File: tb/tb_rat_path_player.sv
// Randomized replay bench: a queue model feeds the player and a walk model predicts every move
// and the final status.
module tb_rat_path_player;

  localparam int MAXP     = 600;
  localparam int STEP_SAT = 511;
  localparam int MAXC     = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] q_out;
  logic       finishq;
  logic       rst_frontq;
  logic       dequeue;
  logic       move_valid;
  logic       move_ready;
  logic [1:0] move_dir;
  logic [3:0] x_o;
  logic [3:0] y_o;
  logic [8:0] step_count;
  logic       busy;
  logic       done;
  logic       at_goal;
  logic       err;

  always #5 clk = ~clk;

  rat_path_player #(
    .COORD_W (4),
    .STEP_W  (9),
    .START_X (0),
    .START_Y (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .q_out      (q_out),
    .finishq    (finishq),
    .rst_frontq (rst_frontq),
    .dequeue    (dequeue),
    .move_valid (move_valid),
    .move_ready (move_ready),
    .move_dir   (move_dir),
    .x_o        (x_o),
    .y_o        (y_o),
    .step_count (step_count),
    .busy       (busy),
    .done       (done),
    .at_goal    (at_goal),
    .err        (err)
  );

  // Path queue model
  logic [1:0] path_mem [MAXP];
  int         path_len = 0;
  int         front = 0;
  assign finishq = (front >= path_len);
  assign q_out   = (front < path_len) ? path_mem[front] : 2'b00;

  // Expected walk
  int exp_x [MAXP];
  int exp_y [MAXP];
  int exp_d [MAXP];
  int exp_n, exp_steps, exp_fx, exp_fy;
  bit exp_err, exp_goal;

  int n_checks = 0;
  int n_errors = 0;
  int dq_cnt, rf_cnt, acc_idx, stall_cnt, cyc_ctr, last_acc, rmode;
  bit spacing_on = 1'b0;
  bit pend_dq = 1'b0;
  bit pend_rf = 1'b0;
  bit prev_stall = 1'b0;
  logic [3:0] px, py;
  logic [1:0] pdir;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic int step_x(input int x, input logic [1:0] d);
    return (d == 2'd1) ? x + 1 : (d == 2'd2) ? x - 1 : x;
  endfunction

  function automatic int step_y(input int y, input logic [1:0] d);
    return (d == 2'd0) ? y + 1 : (d == 2'd3) ? y - 1 : y;
  endfunction

  function automatic bit inside_maze(input int v);
    return (v >= 0) && (v <= MAXC);
  endfunction

  function automatic void build_expect();
    int x, y, nx, ny;
    x = 0; y = 0; exp_n = 0; exp_err = 1'b0;
    for (int i = 0; i < path_len; i++) begin
      nx = step_x(x, path_mem[i]);
      ny = step_y(y, path_mem[i]);
      if (!inside_maze(nx) || !inside_maze(ny)) begin
        exp_err = 1'b1;
        break;
      end
      exp_x[exp_n] = nx; exp_y[exp_n] = ny; exp_d[exp_n] = int'(path_mem[i]);
      x = nx; y = ny;
      exp_n++;
    end
    exp_fx    = x;
    exp_fy    = y;
    exp_steps = (exp_n > STEP_SAT) ? STEP_SAT : exp_n;
    exp_goal  = !exp_err && (x == MAXC) && (y == MAXC);
  endfunction

  // Random walk that mostly stays legal; a wrong-way step is kept 1 time in err_odds.
  task automatic gen_walk(input int len, input int err_odds);
    int x, y;
    logic [1:0] d;
    x = 0; y = 0;
    path_len = len;
    for (int i = 0; i < len; i++) begin
      d = 2'($urandom_range(0, 3));
      if (!inside_maze(step_x(x, d)) || !inside_maze(step_y(y, d))) begin
        if (err_odds == 0 || $urandom_range(1, err_odds) != 1) begin
          for (int t = 0; t < 4; t++) begin
            if (inside_maze(step_x(x, d)) && inside_maze(step_y(y, d))) break;
            d = d + 2'd1;
          end
        end
      end
      path_mem[i] = d;
      if (inside_maze(step_x(x, d)) && inside_maze(step_y(y, d))) begin
        x = step_x(x, d);
        y = step_y(y, d);
      end
    end
  endtask

  // Monitor: samples on the falling edge, well away from the active edge.
  initial begin
    cyc_ctr = 0; dq_cnt = 0; rf_cnt = 0; acc_idx = 0; stall_cnt = 0; last_acc = 0;
    forever begin
      @(negedge clk);
      cyc_ctr++;
      if (rst) begin
        prev_stall = 1'b0; pend_dq = 1'b0; pend_rf = 1'b0;
      end else begin
        pend_dq = dequeue;
        pend_rf = rst_frontq;
        if (dequeue) dq_cnt++;
        if (rst_frontq) rf_cnt++;
        if (dequeue || rst_frontq) check_val("dq_rf_exclusive", 32'(dequeue & rst_frontq), 0);
        if (dequeue || move_valid)
          check_val("dq_only_on_accept", 32'(dequeue), 32'(move_valid & move_ready));
        if (prev_stall) begin
          check_val("stall_valid_held", 32'(move_valid), 1);
          check_val("stall_x_held", 32'(x_o), 32'(px));
          check_val("stall_y_held", 32'(y_o), 32'(py));
          check_val("stall_dir_held", 32'(move_dir), 32'(pdir));
        end
        if (move_valid && move_ready) begin
          if (acc_idx < exp_n) begin
            check_val("move_x", 32'(x_o), exp_x[acc_idx]);
            check_val("move_y", 32'(y_o), exp_y[acc_idx]);
            check_val("move_dir", 32'(move_dir), exp_d[acc_idx]);
          end else begin
            check_val("unexpected_move", acc_idx, exp_n);
          end
          if (spacing_on && acc_idx > 0) check_val("accept_spacing", cyc_ctr - last_acc, 2);
          last_acc = cyc_ctr;
          acc_idx++;
        end
        prev_stall = move_valid && !move_ready;
        if (prev_stall) begin
          stall_cnt++;
          px = x_o; py = y_o; pdir = move_dir;
        end
      end
    end
  end

  // Queue front follows rewind/dequeue pulses seen in the previous cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (pend_rf) front = 0;
      else if (pend_dq) front = front + 1;
      pend_rf = 1'b0;
      pend_dq = 1'b0;
    end
  end

  task automatic set_ready();
    case (rmode)
      0:       move_ready = 1'b1;
      1:       move_ready = 1'($urandom_range(0, 1));
      default: move_ready = (stall_cnt >= 5);
    endcase
  endtask

  task automatic start_pulse();
    @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
  endtask

  task automatic wait_end(input int max_cyc, output int end_cyc);
    int c;
    c = 0;
    set_ready();
    forever begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        check_val("busy_after_start", 32'(busy), 1);
        check_val("done_cleared", 32'(done), 0);
        check_val("err_cleared", 32'(err), 0);
      end
      if (done || err) break;
      if (c >= max_cyc) begin
        check_val("replay_timeout", 32'(done | err), 1);
        break;
      end
      @(posedge clk);
      #2 set_ready();
    end
    end_cyc = c;
  endtask

  task automatic run_case(input string tag, input int mode, input int max_cyc,
                          output int end_cyc);
    build_expect();
    rmode = mode;
    dq_cnt = 0; rf_cnt = 0; acc_idx = 0; stall_cnt = 0;
    start_pulse();
    wait_end(max_cyc, end_cyc);
    #1;
    check_val({tag, "_done"}, 32'(done), 32'(!exp_err));
    check_val({tag, "_err"}, 32'(err), 32'(exp_err));
    check_val({tag, "_at_goal"}, 32'(at_goal), 32'(exp_goal));
    check_val({tag, "_steps"}, 32'(step_count), exp_steps);
    check_val({tag, "_x"}, 32'(x_o), exp_fx);
    check_val({tag, "_y"}, 32'(y_o), exp_fy);
    check_val({tag, "_busy"}, 32'(busy), 0);
    check_val({tag, "_accepts"}, acc_idx, exp_n);
    check_val({tag, "_dequeues"}, dq_cnt, exp_n);
    check_val({tag, "_rewinds"}, rf_cnt, 1);
  endtask

  initial begin
    int ec, c, dq0, rf0;
    rst = 1'b1; start = 1'b0; move_ready = 1'b0; rmode = 0;
    repeat (3) @(posedge clk);
    #2;
    check_val("rst_x", 32'(x_o), 0);
    check_val("rst_y", 32'(y_o), 0);
    check_val("rst_steps", 32'(step_count), 0);
    check_val("rst_flags", 32'({busy, done, at_goal, err, move_valid, dequeue, rst_frontq}), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Short path
    path_len = 3;
    path_mem[0] = 2'b01; path_mem[1] = 2'b01; path_mem[2] = 2'b00;
    run_case("short", 0, 50, ec);

    // Corner to goal, back-to-back accepts
    path_len = 30;
    for (int i = 0; i < 15; i++) path_mem[i] = 2'b01;
    for (int i = 15; i < 30; i++) path_mem[i] = 2'b00;
    spacing_on = 1'b1;
    run_case("to_goal", 0, 200, ec);
    spacing_on = 1'b0;

    // Illegal first move
    path_len = 1;
    path_mem[0] = 2'b10;
    run_case("first_illegal", 0, 20, ec);
    check_val("err_latency", ec, 2);

    // Consumer stall
    path_len = 2;
    path_mem[0] = 2'b01; path_mem[1] = 2'b00;
    run_case("stall", 2, 60, ec);
    check_val("stall_cycles", stall_cnt, 5);

    // Empty path after a non-empty replay
    path_len = 0;
    run_case("empty", 0, 20, ec);
    check_val("empty_latency", ec, 2);
    run_case("empty_again", 1, 20, ec);

    // Reset in the middle of a replay
    path_len = 4;
    for (int i = 0; i < 4; i++) path_mem[i] = 2'b01;
    build_expect();
    rmode = 0; dq_cnt = 0; rf_cnt = 0; acc_idx = 0; stall_cnt = 0;
    start_pulse();
    move_ready = 1'b1;
    c = 0;
    while (acc_idx < 2 && c < 50) begin
      @(negedge clk);
      #1 c++;
    end
    check_val("midrst_two_moves", acc_idx, 2);
    @(posedge clk);
    #2 move_ready = 1'b0;
    c = 0;
    @(negedge clk);
    while (!move_valid && c < 10) begin
      @(negedge clk);
      c++;
    end
    check_val("midrst_in_move", 32'(move_valid), 1);
    #1 rst = 1'b1;
    #1;
    check_val("midrst_x", 32'(x_o), 0);
    check_val("midrst_y", 32'(y_o), 0);
    check_val("midrst_steps", 32'(step_count), 0);
    check_val("midrst_busy", 32'(busy), 0);
    check_val("midrst_valid", 32'(move_valid), 0);
    dq0 = dq_cnt; rf0 = rf_cnt;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    move_ready = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check_val("midrst_no_dequeue", dq_cnt, dq0);
    check_val("midrst_no_rewind", rf_cnt, rf0);
    check_val("midrst_idle", 32'(busy), 0);

    // Random walks with random back-pressure
    for (int r = 0; r < 12; r++) begin
      gen_walk($urandom_range(0, 40), 6);
      run_case("random", 1, 400, ec);
    end

    // Long legal walk saturates the step counter
    gen_walk(520, 0);
    run_case("saturate", 0, 1300, ec);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
